// File: rtl/ysyx_25030093_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, fault codes,
// the canonical nop word and the default boot PC.
package ysyx_25030093_ifu_pkg;

   typedef enum logic [2:0] {
      ST_BOOT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_REQ   = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HOLD  = 3'd4,
      ST_DRAIN = 3'd5
   } ifu_state_e;

   localparam logic [1:0]  FAULT_NONE       = 2'b00;
   localparam logic [1:0]  FAULT_MISALIGN   = 2'b01;
   localparam logic [1:0]  FAULT_ACCESS     = 2'b10;

   // addi x0, x0, 0 -- handed to the decoder in place of a faulted fetch
   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/ysyx_25030093_ifu.sv
// Instruction fetch unit: accepts a PC, performs one outstanding memory read,
// and presents word/PC/fault to the decoder behind a valid/ready handshake.
// Misaligned PCs never touch memory; flushed fetches are drained and dropped.
module ysyx_25030093_ifu
   import ysyx_25030093_ifu_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic              pc_valid,
   output logic              pc_ready,
   input  logic              flush,
   output logic              mem_req_valid,
   input  logic              mem_req_ready,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   input  logic              mem_resp_err,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [1:0]        inst_fault,
   output logic [31:0]       fetch_cnt
);

   ifu_state_e        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
   logic [1:0]        fault_q, fault_d;
   logic [31:0]       cnt_q, cnt_d;
   logic              flush_pend_q, flush_pend_d;

   // State and output register set; reset forces BOOT so any in-flight read is abandoned.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_BOOT;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         inst_pc_q    <= '0;
         fault_q      <= FAULT_NONE;
         cnt_q        <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_pc_q    <= inst_pc_d;
         fault_q      <= fault_d;
         cnt_q        <= cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   // Next-state, handshake outputs and captured-instruction updates.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      inst_d        = inst_q;
      inst_pc_d     = inst_pc_q;
      fault_d       = fault_q;
      cnt_d         = cnt_q;
      flush_pend_d  = flush_pend_q;
      pc_ready      = 1'b0;
      mem_req_valid = 1'b0;
      inst_valid    = 1'b0;

      case (state_q)
         ST_BOOT: begin
            pc_d    = RESET_PC;
            state_d = ST_REQ;
         end
         ST_IDLE: begin
            pc_ready = !flush;
         end
         ST_REQ: begin
            // A request once raised is never retracted; a flush is remembered instead.
            mem_req_valid = 1'b1;
            if (mem_req_ready) begin
               if (flush_pend_q || flush) begin
                  state_d      = ST_DRAIN;
                  flush_pend_d = 1'b0;
               end else begin
                  state_d = ST_WAIT;
               end
            end else if (flush) begin
               flush_pend_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (mem_resp_valid) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d   = ST_HOLD;
                  inst_pc_d = pc_q;
                  if (mem_resp_err) begin
                     inst_d  = DATA_W'(INST_NOP);
                     fault_d = FAULT_ACCESS;
                  end else begin
                     inst_d  = mem_resp_data;
                     fault_d = FAULT_NONE;
                  end
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_HOLD: begin
            inst_valid = 1'b1;
            if (flush) begin
               state_d = ST_IDLE;
            end else if (inst_ready) begin
               cnt_d    = cnt_q + 32'd1;
               pc_ready = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_resp_valid) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase

      // PC acceptance is shared by IDLE and the back-to-back path out of HOLD.
      if (pc_ready && pc_valid) begin
         pc_d = pc_in;
         if (pc_in[1:0] != 2'b00) begin
            state_d   = ST_HOLD;
            inst_d    = DATA_W'(INST_NOP);
            inst_pc_d = pc_in;
            fault_d   = FAULT_MISALIGN;
         end else begin
            state_d = ST_REQ;
         end
      end
   end

   assign mem_req_addr = {pc_q[ADDR_W-1:2], 2'b00};
   assign inst         = inst_q;
   assign inst_pc      = inst_pc_q;
   assign inst_fault   = fault_q;
   assign fetch_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_25030093_ifu.sv
// Testbench for the fetch unit: a behavioural memory with configurable ready
// and latency, directed scenarios, and a randomized stream checked against a
// queue of expected deliveries computed from the fetch rules.
module tb_ysyx_25030093_ifu;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] w;
      logic [31:0] pc;
      logic [1:0]  f;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   logic        mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        mem_resp_err;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic [1:0]  inst_fault;
   logic [31:0] fetch_cnt;

   int          n_checks = 0;
   int          n_pass   = 0;
   int          hs_cnt   = 0;
   logic [31:0] exp_cnt  = 32'd0;
   bit          cfg_rdy      = 1'b1;
   bit          cfg_rdy_rand = 1'b0;
   int          cfg_lat      = 0;

   ysyx_25030093_ifu dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .pc_valid       (pc_valid),
      .pc_ready       (pc_ready),
      .flush          (flush),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .mem_resp_err   (mem_resp_err),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst           (inst),
      .inst_pc        (inst_pc),
      .inst_fault     (inst_fault),
      .fetch_cnt      (fetch_cnt)
   );

   always #5 clk = ~clk;

   // Memory contents as seen by the bench.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0093;
      if (a == 32'h8000_0020) return 32'hDEAD_BEEF;
      return a ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic mem_err(input logic [31:0] a);
      return (a == 32'h8000_0010) || (a[11:8] == 4'hE);
   endfunction

   // What the decoder should receive for a fetch from pc.
   function automatic exp_t model(input logic [31:0] pc);
      exp_t e;
      e.pc = pc;
      if (pc[1:0] != 2'b00) begin
         e.w = NOP;
         e.f = 2'b01;
      end else if (mem_err(pc)) begin
         e.w = NOP;
         e.f = 2'b10;
      end else begin
         e.w = mem_word(pc);
         e.f = 2'b00;
      end
      return e;
   endfunction

   // Behavioural memory: one response per accepted request, cfg_lat extra cycles.
   initial begin : mem_model
      bit          busy;
      int          wcnt;
      logic [31:0] maddr;
      bit          rv_n;
      bit          rdy_n;
      busy = 1'b0;
      wcnt = 0;
      maddr = 32'd0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'd0;
      mem_resp_err   = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
         end else begin
            if (mem_resp_valid) busy = 1'b0;
            if (mem_req_valid && mem_req_ready) begin
               busy  = 1'b1;
               wcnt  = cfg_lat;
               maddr = mem_req_addr;
               hs_cnt++;
            end else if (busy && wcnt > 0) begin
               wcnt--;
            end
         end
         rv_n  = busy && (wcnt == 0) && !rst;
         rdy_n = cfg_rdy_rand ? 1'($urandom_range(0, 1)) : cfg_rdy;
         @(posedge clk);
         #1;
         mem_resp_valid = rv_n;
         mem_resp_data  = rv_n ? mem_word(maddr) : 32'd0;
         mem_resp_err   = rv_n && mem_err(maddr);
         mem_req_ready  = rdy_n;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present pc until accepted; returns just after the accepting edge.
   task automatic present_pc(input logic [31:0] pc, output bit ok);
      ok = 1'b0;
      step();
      pc_in    = pc;
      pc_valid = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (pc_ready) begin
            ok = 1'b1;
            break;
         end
      end
      step();
      pc_valid = 1'b0;
   endtask

   // Wait for inst_valid; ncyc is the cycle index (from 1) on which it appeared.
   task automatic wait_inst(input int max, output bit ok, output int ncyc);
      ok   = 1'b0;
      ncyc = 0;
      for (int i = 0; i < max; i++) begin
         @(negedge clk);
         if (inst_valid) begin
            ok   = 1'b1;
            ncyc = i + 1;
            break;
         end
      end
   endtask

   task automatic consume(input string tag);
      step();
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      exp_cnt++;
      @(negedge clk);
      n_checks++;
      if (fetch_cnt !== exp_cnt)
         $display("FAIL %s_fetch_cnt got %0d expected %0d", tag, fetch_cnt, exp_cnt);
      else n_pass++;
   endtask

   task automatic fetch_check(input logic [31:0] pc, input int exp_lat, input string tag);
      exp_t e;
      bit   ok;
      int   ncyc;
      e = model(pc);
      present_pc(pc, ok);
      n_checks++;
      if (!ok) $display("FAIL %s_accept got no pc_ready expected pc_ready within 40 cycles", tag);
      else n_pass++;
      wait_inst(40, ok, ncyc);
      n_checks++;
      if (!ok) $display("FAIL %s_inst_valid got timeout expected inst_valid within 40 cycles", tag);
      else n_pass++;
      if (ok) begin
         n_checks++;
         if (inst !== e.w || inst_pc !== e.pc || inst_fault !== e.f)
            $display("FAIL %s_data got inst=%h pc=%h fault=%b expected inst=%h pc=%h fault=%b",
                     tag, inst, inst_pc, inst_fault, e.w, e.pc, e.f);
         else n_pass++;
         if (exp_lat > 0) begin
            n_checks++;
            if (ncyc != exp_lat) $display("FAIL %s_latency got %0d expected %0d", tag, ncyc, exp_lat);
            else n_pass++;
         end
      end
      $display("txn %s pc=%h inst=%h fault=%b", tag, inst_pc, inst, inst_fault);
      consume(tag);
   endtask

   task automatic test_reset();
      bit ok;
      int ncyc;
      rst = 1'b1;
      repeat (3) step();
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0 || pc_ready !== 1'b0)
         $display("FAIL reset_valids got iv=%b rv=%b pr=%b expected 0 0 0", inst_valid, mem_req_valid, pc_ready);
      else n_pass++;
      n_checks++;
      if (fetch_cnt !== 32'd0 || inst !== 32'd0 || inst_pc !== 32'd0 || inst_fault !== 2'b00)
         $display("FAIL reset_regs got cnt=%0d inst=%h pc=%h fault=%b expected all zero", fetch_cnt, inst, inst_pc, inst_fault);
      else n_pass++;
      step();
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b0) $display("FAIL boot_cycle got mem_req_valid=%b expected 0", mem_req_valid);
      else n_pass++;
      step();
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000)
         $display("FAIL boot_req got valid=%b addr=%h expected 1 80000000", mem_req_valid, mem_req_addr);
      else n_pass++;
      wait_inst(20, ok, ncyc);
      n_checks++;
      if (!ok || inst !== 32'h0000_0093 || inst_pc !== 32'h8000_0000 || inst_fault !== 2'b00)
         $display("FAIL boot_inst got ok=%b inst=%h pc=%h fault=%b expected 1 00000093 80000000 00",
                  ok, inst, inst_pc, inst_fault);
      else n_pass++;
      $display("txn boot pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
      consume("boot");
   endtask

   task automatic test_misaligned();
      int h0;
      h0 = hs_cnt;
      fetch_check(32'h8000_0006, 1, "misalign");
      n_checks++;
      if (hs_cnt != h0) $display("FAIL misalign_no_mem got %0d handshakes expected 0", hs_cnt - h0);
      else n_pass++;
   endtask

   task automatic test_access_fault();
      fetch_check(32'h8000_0010, 3, "access_fault");
   endtask

   task automatic test_req_stall();
      bit   ok;
      int   ncyc;
      int   h0;
      exp_t e;
      e = model(32'h8000_0040);
      cfg_rdy = 1'b0;
      step();
      step();
      h0 = hs_cnt;
      present_pc(32'h8000_0040, ok);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0040)
            $display("FAIL req_stall_%0d got valid=%b addr=%h expected 1 80000040", i, mem_req_valid, mem_req_addr);
         else n_pass++;
         step();
      end
      cfg_rdy = 1'b1;
      wait_inst(40, ok, ncyc);
      n_checks++;
      if (!ok || inst !== e.w || inst_fault !== e.f)
         $display("FAIL req_stall_inst got ok=%b inst=%h fault=%b expected 1 %h %b", ok, inst, inst_fault, e.w, e.f);
      else n_pass++;
      n_checks++;
      if (hs_cnt - h0 != 1) $display("FAIL req_stall_handshakes got %0d expected 1", hs_cnt - h0);
      else n_pass++;
      $display("txn req_stall pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
      consume("req_stall");
   endtask

   task automatic test_flush_wait();
      bit ok;
      bit bad;
      int seen;
      int got;
      cfg_lat = 2;
      present_pc(32'h8000_0020, ok);
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_ready !== 1'b1)
         $display("FAIL flush_wait_req got valid=%b ready=%b expected 1 1", mem_req_valid, mem_req_ready);
      else n_pass++;
      step();
      flush = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pc_ready !== 1'b0) $display("FAIL flush_wait_pc_ready got %b expected 0", pc_ready);
      else n_pass++;
      step();
      flush = 1'b0;
      bad  = 1'b0;
      seen = -1;
      got  = -1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (inst_valid) bad = 1'b1;
         if (mem_resp_valid && seen < 0) seen = i;
         if (pc_ready) begin
            got = i;
            break;
         end
      end
      n_checks++;
      if (bad) $display("FAIL flush_wait_dropped got inst_valid=1 expected 0");
      else n_pass++;
      n_checks++;
      if (seen < 0 || got != seen + 1)
         $display("FAIL flush_wait_ready_timing got resp@%0d ready@%0d expected ready one cycle after resp", seen, got);
      else n_pass++;
      n_checks++;
      if (fetch_cnt !== exp_cnt) $display("FAIL flush_wait_cnt got %0d expected %0d", fetch_cnt, exp_cnt);
      else n_pass++;
      cfg_lat = 0;
   endtask

   task automatic test_hold_b2b();
      bit   ok;
      int   ncyc;
      exp_t e0;
      exp_t e1;
      e0 = model(32'h8000_0008);
      e1 = model(32'h8000_0004);
      present_pc(32'h8000_0008, ok);
      wait_inst(40, ok, ncyc);
      n_checks++;
      if (!ok) $display("FAIL hold_inst_valid got timeout expected inst_valid");
      else n_pass++;
      step();
      pc_in    = 32'h8000_0004;
      pc_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_checks++;
         if (inst_valid !== 1'b1 || inst !== e0.w || inst_pc !== e0.pc || inst_fault !== e0.f || pc_ready !== 1'b0)
            $display("FAIL hold_stable_%0d got iv=%b inst=%h pc=%h fault=%b pr=%b expected 1 %h %h %b 0",
                     i, inst_valid, inst, inst_pc, inst_fault, pc_ready, e0.w, e0.pc, e0.f);
         else n_pass++;
         step();
      end
      inst_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pc_ready !== 1'b1) $display("FAIL b2b_pc_ready got %b expected 1", pc_ready);
      else n_pass++;
      step();
      inst_ready = 1'b0;
      pc_valid   = 1'b0;
      exp_cnt++;
      $display("txn hold pc=%h inst=%h fault=%b", e0.pc, e0.w, e0.f);
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0004 || inst_valid !== 1'b0)
         $display("FAIL b2b_req got valid=%b addr=%h iv=%b expected 1 80000004 0", mem_req_valid, mem_req_addr, inst_valid);
      else n_pass++;
      n_checks++;
      if (fetch_cnt !== exp_cnt) $display("FAIL b2b_cnt got %0d expected %0d", fetch_cnt, exp_cnt);
      else n_pass++;
      wait_inst(40, ok, ncyc);
      n_checks++;
      if (!ok || inst !== e1.w || inst_pc !== e1.pc || inst_fault !== e1.f)
         $display("FAIL b2b_inst got ok=%b inst=%h pc=%h fault=%b expected 1 %h %h %b",
                  ok, inst, inst_pc, inst_fault, e1.w, e1.pc, e1.f);
      else n_pass++;
      $display("txn b2b pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
      consume("b2b");
   endtask

   task automatic test_flush_hold();
      bit ok;
      int ncyc;
      present_pc(32'h8000_000C, ok);
      wait_inst(40, ok, ncyc);
      step();
      flush      = 1'b1;
      inst_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (pc_ready !== 1'b0) $display("FAIL flush_hold_pc_ready got %b expected 0", pc_ready);
      else n_pass++;
      step();
      flush      = 1'b0;
      inst_ready = 1'b0;
      @(negedge clk);
      n_checks++;
      if (inst_valid !== 1'b0 || pc_ready !== 1'b1)
         $display("FAIL flush_hold_state got iv=%b pr=%b expected 0 1", inst_valid, pc_ready);
      else n_pass++;
      n_checks++;
      if (fetch_cnt !== exp_cnt) $display("FAIL flush_hold_cnt got %0d expected %0d", fetch_cnt, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_flush_req();
      bit ok;
      bit bad;
      int got;
      int h0;
      cfg_rdy = 1'b0;
      step();
      step();
      h0 = hs_cnt;
      present_pc(32'h8000_0030, ok);
      flush = 1'b1;
      step();
      flush = 1'b0;
      @(negedge clk);
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0030)
         $display("FAIL flush_req_held got valid=%b addr=%h expected 1 80000030", mem_req_valid, mem_req_addr);
      else n_pass++;
      step();
      cfg_rdy = 1'b1;
      bad = 1'b0;
      got = -1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (inst_valid) bad = 1'b1;
         if (pc_ready) begin
            got = i;
            break;
         end
      end
      n_checks++;
      if (bad || got < 0) $display("FAIL flush_req_drop got iv_seen=%b ready@%0d expected no inst and pc_ready", bad, got);
      else n_pass++;
      n_checks++;
      if (hs_cnt - h0 != 1) $display("FAIL flush_req_handshakes got %0d expected 1", hs_cnt - h0);
      else n_pass++;
   endtask

   task automatic test_random();
      exp_t        q[$];
      exp_t        e;
      logic [31:0] rp;
      int          sent;
      int          got;
      sent = 0;
      got  = 0;
      cfg_rdy_rand = 1'b1;
      for (int cyc = 0; cyc < 4000 && got < 40; cyc++) begin
         step();
         cfg_lat = $urandom_range(0, 3);
         rp = 32'h8000_0000 + ($urandom_range(0, 1023) << 2);
         if ($urandom_range(0, 4) == 0) rp = rp | $urandom_range(1, 3);
         pc_in      = rp;
         pc_valid   = (sent < 40) && ($urandom_range(0, 3) != 0);
         inst_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (pc_valid && pc_ready) begin
            q.push_back(model(pc_in));
            sent++;
         end
         if (inst_valid && inst_ready) begin
            n_checks++;
            if (q.size() == 0) begin
               $display("FAIL rand_unexpected got inst=%h pc=%h expected no delivery", inst, inst_pc);
            end else begin
               e = q.pop_front();
               if (inst !== e.w || inst_pc !== e.pc || inst_fault !== e.f)
                  $display("FAIL rand_%0d got inst=%h pc=%h fault=%b expected inst=%h pc=%h fault=%b",
                           got, inst, inst_pc, inst_fault, e.w, e.pc, e.f);
               else n_pass++;
            end
            $display("txn rand_%0d pc=%h inst=%h fault=%b", got, inst_pc, inst, inst_fault);
            got++;
            exp_cnt++;
         end
      end
      step();
      pc_valid     = 1'b0;
      inst_ready   = 1'b0;
      cfg_rdy_rand = 1'b0;
      cfg_rdy      = 1'b1;
      cfg_lat      = 0;
      @(negedge clk);
      n_checks++;
      if (got != 40 || q.size() != 0) $display("FAIL rand_count got %0d delivered (%0d pending) expected 40", got, q.size());
      else n_pass++;
      n_checks++;
      if (fetch_cnt !== exp_cnt) $display("FAIL rand_cnt got %0d expected %0d", fetch_cnt, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_rst_mid();
      bit ok;
      int ncyc;
      cfg_lat = 3;
      present_pc(32'h8000_0044, ok);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req_valid && mem_req_ready) break;
      end
      step();
      rst     = 1'b1;
      cfg_lat = 0;
      step();
      step();
      rst     = 1'b0;
      exp_cnt = 32'd0;
      @(negedge clk);
      n_checks++;
      if (fetch_cnt !== 32'd0 || inst_valid !== 1'b0)
         $display("FAIL rst_mid_state got cnt=%0d iv=%b expected 0 0", fetch_cnt, inst_valid);
      else n_pass++;
      wait_inst(20, ok, ncyc);
      n_checks++;
      if (!ok || inst !== 32'h0000_0093 || inst_pc !== 32'h8000_0000 || inst_fault !== 2'b00)
         $display("FAIL rst_mid_refetch got ok=%b inst=%h pc=%h fault=%b expected 1 00000093 80000000 00",
                  ok, inst, inst_pc, inst_fault);
      else n_pass++;
      $display("txn rst_mid pc=%h inst=%h fault=%b", inst_pc, inst, inst_fault);
      consume("rst_mid");
   endtask

   initial begin
      rst        = 1'b1;
      pc_in      = 32'd0;
      pc_valid   = 1'b0;
      flush      = 1'b0;
      inst_ready = 1'b0;
      test_reset();
      test_misaligned();
      test_access_fault();
      test_req_stall();
      test_flush_wait();
      test_hold_b2b();
      test_flush_hold();
      test_flush_req();
      test_random();
      test_rst_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25030093_ifu.md
Name: ysyx_25030093_ifu

Overview:
Instruction fetch unit directly upstream of the decode/execute core. Takes the next PC from the PC unit and issues a single outstanding read to instruction memory over a valid/ready request channel plus a response channel. Presents the fetched word, its PC and a fault flag to the decoder with a valid/ready handshake. Replaces the core's direct combinational inst input, so memory latency is absorbed here.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
RESET_PC, 32'h8000_0000, PC fetched automatically after reset

Ports:
clk  in  1  core clock, all state on rising edge
rst  in  1  synchronous, active-high reset
pc_in  in  ADDR_W  next PC from PC unit
pc_valid  in  1  pc_in valid
pc_ready  out  1  IFU accepts pc_in this cycle
flush  in  1  discard any in-flight or held fetch
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_W  read address, always word-aligned
mem_resp_valid  in  1  read data valid (exactly one per accepted request, at least 1 cycle after acceptance)
mem_resp_data  in  DATA_W  read data
mem_resp_err  in  1  access fault, qualified by mem_resp_valid
inst_valid  out  1  inst/inst_pc/inst_fault valid
inst_ready  in  1  decoder consumes instruction
inst  out  DATA_W  fetched word; 32'h0000_0013 (nop) when inst_fault=1
inst_pc  out  ADDR_W  PC of inst
inst_fault  out  2  00 ok, 01 misaligned PC, 10 access fault
fetch_cnt  out  32  count of instructions delivered (inst_valid & inst_ready)

Behaviour:
- States: BOOT, IDLE, REQ, WAIT, HOLD, DRAIN. Reset -> BOOT; registers: pc_q=RESET_PC, all valids 0, inst=0, inst_pc=0, inst_fault=0, fetch_cnt=0, flush_pend=0.
- BOOT: one cycle, then REQ with pc_q=RESET_PC (no pc_in handshake).
- IDLE: pc_ready=1. pc_valid -> latch pc_in. If pc_in[1:0]!=0 -> HOLD with inst=nop, inst_fault=01, no memory access; else -> REQ.
- REQ: mem_req_valid=1, mem_req_addr=pc_q; addr/valid held stable until mem_req_ready. Handshake -> WAIT (or DRAIN if flush_pend or flush this cycle).
- WAIT: mem_resp_valid -> latch data; err -> inst=nop, inst_fault=10; -> HOLD. Response same cycle as flush -> discarded, -> IDLE.
- HOLD: inst_valid=1, outputs stable until inst_ready. inst_ready & pc_valid same cycle -> pc_ready=1, accept directly (back-to-back, no IDLE bubble), next state per IDLE rules. inst_ready alone -> IDLE.
- DRAIN: await mem_resp_valid, discard data, -> IDLE. pc_ready=0.
- flush: HOLD -> IDLE, inst_valid drops next cycle, fetch_cnt not incremented. WAIT -> DRAIN. REQ: request still completes (no retraction); flush_pend set, cleared on entry to DRAIN. IDLE/DRAIN: no effect. flush has priority over pc_valid: pc_ready=0 while flush=1.
- Latency: minimum pc accept -> inst_valid = 3 cycles (REQ, WAIT with zero-wait memory, HOLD).
- pc_ready only in IDLE, or HOLD with inst_ready & !flush.
- fetch_cnt wraps 32'hFFFF_FFFF -> 0; increments on faulted instructions too.
- rst mid-transaction: state -> BOOT immediately; a memory response for the abandoned request must not be delivered (memory is reset by the same rst).

Decomposition:
- Shared package: state encoding enum, fault codes (FAULT_NONE/MISALIGN/ACCESS), NOP constant 32'h0000_0013, RESET_PC default.
- No sub-module; FSM, output register set and counter in one module.

Test Plan:
- Reset, mem_req_ready=1, response 1 cycle later with 32'h0000_0093 -> first request addr 32'h8000_0000; inst_valid with inst=32'h0000_0093, inst_pc=32'h8000_0000, fault=00.
- pc_in=32'h8000_0006 -> no mem_req_valid; inst_valid, inst=32'h0000_0013, fault=01, inst_pc=32'h8000_0006.
- mem_resp_err=1 for pc 32'h8000_0010 -> inst=nop, fault=10; fetch_cnt increments on consume.
- mem_req_ready low 5 cycles -> mem_req_valid and addr stable all 5 cycles; exactly one handshake.
- flush in WAIT, response 3 cycles later with 32'hDEAD_BEEF -> inst_valid never asserts with that word; pc_ready returns 1 the cycle after response.
- inst_ready=0 for 4 cycles in HOLD, then inst_ready=1 with pc_valid=1 (32'h8000_0004) -> outputs stable while stalled; new request issued next cycle; fetch_cnt +1.
